// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared bus widths for the simple_processor core
package simple_processor_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
endpackage

// File: rtl/simple_processor_mem_arbiter.sv
// rtl/simple_processor_mem_arbiter.sv - round-robin instruction/data arbiter onto one memory port
// One transaction outstanding; watchdog aborts a stalled access with an error ack.
module simple_processor_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      imem_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
  output logic [MEM_DATA_WIDTH-1:0] imem_rdata_o,
  output logic                      imem_ack_o,
  output logic                      imem_err_o,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o,
  output logic                      dmem_err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                      mem_ack_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  // Counter is kept one bit wide when the watchdog is disabled so the logic still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]                state_q, state_d;
  logic                      last_d_q, last_d_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic granted, expire, done, pick_d, pick_i;

  always_comb begin
    granted = (state_q == GNT_I) || (state_q == GNT_D);
    expire  = (TIMEOUT_CYCLES != 0) && granted && !mem_ack_i && (cnt_q == CNT_LAST);
    done    = granted && (mem_ack_i || expire);
    // On a tie the port that did not win last time goes first.
    pick_d  = dmem_req_i && (!imem_req_i || !last_d_q);
    pick_i  = imem_req_i && !pick_d;
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = dmem_we_i;
          addr_d   = dmem_addr_i;
          wdata_d  = dmem_wdata_i;
        end else if (pick_i) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = imem_addr_i;
          wdata_d  = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Responses are combinational so the owner sees its ack in the memory's ack cycle.
  always_comb begin
    imem_ack_o   = done && (state_q == GNT_I);
    imem_err_o   = expire && (state_q == GNT_I);
    imem_rdata_o = ((state_q == GNT_I) && mem_ack_i) ? mem_rdata_i : '0;
    dmem_ack_o   = done && (state_q == GNT_D);
    dmem_err_o   = expire && (state_q == GNT_D);
    dmem_rdata_o = ((state_q == GNT_D) && mem_ack_i) ? mem_rdata_i : '0;
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_simple_processor_mem_arbiter.sv
// tb/tb_simple_processor_mem_arbiter.sv - scoreboard bench for simple_processor_mem_arbiter
module tb_simple_processor_mem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic        clk, arst_ni;
  logic        imem_req_i, imem_ack_o, imem_err_o;
  logic [15:0] imem_addr_i, imem_rdata_o;
  logic        dmem_req_i, dmem_we_i, dmem_ack_o, dmem_err_o;
  logic [15:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int   checks, errors;
  exp_t sb[$];
  int   mem_lat, hi_cnt, hi_len, last_hi_len, low_cnt;
  int   acks_i, acks_d, tgt_i, tgt_d;
  logic stray, req_prev, gap_en, had_rise;

  simple_processor_mem_arbiter #(
    .MEM_ADDR_WIDTH(16), .MEM_DATA_WIDTH(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_rdata_o(imem_rdata_o),
    .imem_ack_o(imem_ack_o), .imem_err_o(imem_err_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_rdata_o(dmem_rdata_o),
    .dmem_ack_o(dmem_ack_o), .dmem_err_o(dmem_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  task automatic push_exp(input logic port, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic err, input logic [15:0] rdata);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic drive_i(input logic [15:0] addr, input int n);
    imem_addr_i = addr;
    imem_req_i  = 1'b1;
    tgt_i       = acks_i + n;
  endtask

  task automatic drive_d(input logic we, input logic [15:0] addr, input logic [15:0] wdata, input int n);
    dmem_we_i    = we;
    dmem_addr_i  = addr;
    dmem_wdata_i = wdata;
    dmem_req_i   = 1'b1;
    tgt_d        = acks_d + n;
  endtask

  // Drops each request once its owner has collected its acks; bounded.
  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles) begin
      @(negedge clk);
      #3;
      if (acks_i >= tgt_i) imem_req_i = 1'b0;
      if (acks_d >= tgt_d) dmem_req_i = 1'b0;
      if (sb.size() == 0 && !imem_req_i && !dmem_req_i) break;
      n++;
    end
    if (n >= max_cycles) begin
      chk("wait_idle_timeout", 64'(sb.size()), 64'd0);
      imem_req_i = 1'b0;
      dmem_req_i = 1'b0;
      sb.delete();
    end
  endtask

  // Memory model
  always @(negedge clk) begin
    #1;
    mem_rdata_i = rd_fn(mem_addr_o);
    if (mem_req_o) begin
      mem_ack_i = (hi_cnt == mem_lat);
      hi_cnt++;
    end else begin
      mem_ack_i = stray;
      hi_cnt = 0;
    end
  end

  // Monitor: request issue and response checks against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mem_req_o && !req_prev) begin
      if (sb.size() == 0) chk("spurious_req", 64'd1, 64'd0);
      else begin
        chk("req_we", 64'(mem_we_o), 64'(sb[0].we));
        chk("req_addr", 64'(mem_addr_o), 64'(sb[0].addr));
        chk("req_wdata", 64'(mem_wdata_o), 64'(sb[0].wdata));
      end
      if (gap_en && had_rise) chk("req_gap", 64'(low_cnt), 64'd1);
      had_rise = 1'b1;
      hi_len   = 0;
      low_cnt  = 0;
    end
    if (mem_req_o) hi_len++;
    else low_cnt++;
    if (!mem_req_o && req_prev) last_hi_len = hi_len;
    req_prev = mem_req_o;

    if (imem_ack_o && dmem_ack_o) chk("dual_ack", 64'd1, 64'd0);
    if (imem_ack_o || dmem_ack_o) begin
      if (sb.size() == 0) chk("spurious_ack", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("ack_port", 64'(dmem_ack_o), 64'(e.port));
        if (dmem_ack_o) begin
          chk("d_err", 64'(dmem_err_o), 64'(e.err));
          chk("d_rdata", 64'(dmem_rdata_o), 64'(e.rdata));
          chk("i_quiet", {imem_ack_o, imem_err_o, imem_rdata_o}, 64'd0);
          acks_d++;
        end else begin
          chk("i_err", 64'(imem_err_o), 64'(e.err));
          chk("i_rdata", 64'(imem_rdata_o), 64'(e.rdata));
          chk("d_quiet", {dmem_ack_o, dmem_err_o, dmem_rdata_o}, 64'd0);
          acks_i++;
        end
      end
    end
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    arst_ni = 1'b0; stray = 1'b0; mem_lat = 0;
    imem_req_i = 1'b0; imem_addr_i = '0;
    dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    hi_cnt = 0; hi_len = 0; last_hi_len = 0; low_cnt = 0;
    acks_i = 0; acks_d = 0; tgt_i = 0; tgt_d = 0;
    req_prev = 1'b0; gap_en = 1'b0; had_rise = 1'b0;

    #3;
    chk("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
    chk("rst_resp", {imem_ack_o, imem_err_o, imem_rdata_o, dmem_ack_o, dmem_err_o, dmem_rdata_o}, 64'd0);
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;

    // First tie after reset goes to D, then I
    @(negedge clk);
    mem_lat = 1;
    push_exp(1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, rd_fn(16'h0200));
    push_exp(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, rd_fn(16'h0010));
    drive_d(1'b1, 16'h0200, 16'h1234, 1);
    drive_i(16'h0010, 1);
    wait_idle(40);

    // Single instruction fetch, ack 2 cycles after mem_req_o rises
    mem_lat = 2;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'hBEEF);
    drive_i(16'h0100, 1);
    @(negedge clk);
    #3 chk("grant_lat", 64'(mem_req_o), 64'd1);
    wait_idle(40);

    // Both held for four transactions, immediate acks
    mem_lat = 0;
    @(negedge clk);
    push_exp(1'b1, 1'b0, 16'h0500, 16'h00AA, 1'b0, rd_fn(16'h0500));
    push_exp(1'b0, 1'b0, 16'h0600, 16'h0000, 1'b0, rd_fn(16'h0600));
    push_exp(1'b1, 1'b0, 16'h0500, 16'h00AA, 1'b0, rd_fn(16'h0500));
    push_exp(1'b0, 1'b0, 16'h0600, 16'h0000, 1'b0, rd_fn(16'h0600));
    gap_en = 1'b1; had_rise = 1'b0;
    drive_d(1'b0, 16'h0500, 16'h00AA, 2);
    drive_i(16'h0600, 2);
    wait_idle(60);
    gap_en = 1'b0;

    // Watchdog abort, then a late ack that must be ignored
    mem_lat = 99;
    @(negedge clk);
    push_exp(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 16'h0000);
    drive_d(1'b0, 16'h0300, 16'h0000, 1);
    wait_idle(40);
    @(negedge clk);
    #3 chk("timeout_req_len", 64'(last_hi_len), 64'd4);
    @(negedge clk);
    stray = 1'b1;
    #3 chk("late_ack_ignored", {imem_ack_o, dmem_ack_o, imem_err_o, dmem_err_o}, 64'd0);
    @(negedge clk);
    stray = 1'b0;

    // Ack coincides with expiry: ack wins
    mem_lat = 3;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 16'h0700, 16'h0000, 1'b0, rd_fn(16'h0700));
    drive_i(16'h0700, 1);
    wait_idle(40);
    @(negedge clk);
    #3 chk("edge_req_len", 64'(last_hi_len), 64'd4);

    // Reset while GNT_I waits
    mem_lat = 99;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 16'h0400, 16'h0000, 1'b0, rd_fn(16'h0400));
    drive_i(16'h0400, 1);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!mem_req_o && n < 20);
    chk("mid_rst_granted", 64'(mem_req_o), 64'd1);
    @(negedge clk);
    arst_ni = 1'b0;
    imem_req_i = 1'b0;
    tgt_i = acks_i;
    sb.delete();
    #1;
    chk("mid_rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
    chk("mid_rst_resp", {imem_ack_o, imem_err_o, imem_rdata_o, dmem_ack_o, dmem_err_o, dmem_rdata_o}, 64'd0);
    @(negedge clk);
    arst_ni = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    #3 chk("post_rst_stray", {mem_req_o, imem_ack_o, dmem_ack_o}, 64'd0);
    @(negedge clk);
    stray = 1'b0;

    // Fresh request after reset is served normally
    mem_lat = 1;
    push_exp(1'b1, 1'b1, 16'h0800, 16'hCAFE, 1'b0, rd_fn(16'h0800));
    drive_d(1'b1, 16'h0800, 16'hCAFE, 1);
    wait_idle(40);
    chk("fresh_acks_d", 64'(acks_d), 64'd5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_processor_mem_arbiter.md
Name:
simple_processor_mem_arbiter

Overview:
- Shares one single-ported memory between the instruction and data request ports of simple_processor.
- Requester side matches the core's req/ack buses. Memory side is the same req/we/addr/wdata/rdata/ack handshake, presented once.
- Sits between the core and the unified memory model/SRAM wrapper.
- One transaction outstanding at a time; round-robin on ties; optional watchdog timeout that returns an error.

Parameters:
- MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, address bus width.
- MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, data bus width.
- TIMEOUT_CYCLES, 16, maximum cycles mem_req_o stays high without mem_ack_i; 0 disables the watchdog.

Ports:
- clk_i  in  1  global synchronous clock, rising edge
- arst_ni  in  1  asynchronous reset, active low
- imem_req_i  in  1  instruction read request, held until imem_ack_o
- imem_addr_i  in  MEM_ADDR_WIDTH  instruction address
- imem_rdata_o  out  MEM_DATA_WIDTH  instruction read data, valid with imem_ack_o
- imem_ack_o  out  1  instruction transaction done, 1-cycle pulse
- imem_err_o  out  1  instruction timeout, valid with imem_ack_o
- dmem_req_i  in  1  data request, held until dmem_ack_o
- dmem_we_i  in  1  data write enable
- dmem_addr_i  in  MEM_ADDR_WIDTH  data address
- dmem_wdata_i  in  MEM_DATA_WIDTH  data write data
- dmem_rdata_o  out  MEM_DATA_WIDTH  data read data, valid with dmem_ack_o
- dmem_ack_o  out  1  data transaction done, 1-cycle pulse
- dmem_err_o  out  1  data timeout, valid with dmem_ack_o
- mem_req_o  out  1  shared memory request
- mem_we_o  out  1  shared memory write enable
- mem_addr_o  out  MEM_ADDR_WIDTH  shared memory address
- mem_wdata_o  out  MEM_DATA_WIDTH  shared memory write data
- mem_rdata_i  in  MEM_DATA_WIDTH  shared memory read data
- mem_ack_i  in  1  shared memory done

Behaviour:
- Reset (arst_ni low, asynchronous):
  - state IDLE, last_grant=I, timeout counter 0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o all 0.
  - All *_ack_o, *_err_o and *_rdata_o are 0.
  - Deassertion takes effect at the next clk_i edge.
- FSM states:
  - IDLE: mem_req_o=0.
    - Only dmem_req_i high -> GNT_D. Only imem_req_i high -> GNT_I.
    - Both high -> grant the port not equal to last_grant; last_grant is updated at grant.
    - So after reset the first tie goes to D, and ties alternate thereafter.
    - On grant edge: register mem_addr_o, mem_we_o (dmem_we_i for D, 0 for I) and mem_wdata_o (dmem_wdata_i for D, 0 for I). Set mem_req_o=1.
  - GNT_I / GNT_D: mem_req_o and the registered address/we/wdata are held stable.
    - On the mem_ack_i cycle: the granted port's ack_o=1 combinationally in the same cycle, and its rdata_o=mem_rdata_i in that cycle (0 for writes is not required; pass-through).
    - The next edge goes to IDLE with mem_req_o=0. Re-arbitration therefore happens in the following IDLE cycle: 2 cycles minimum per transaction.
- Grant latency: request seen at edge N -> mem_req_o high after edge N. Memory may ack in the first cycle mem_req_o is high.
- Requester inputs are sampled only at the grant edge. Changes while granted are ignored.
- mem_ack_i in IDLE is ignored: no acks, no state change.
- The non-granted port sees ack_o=0, err_o=0 and rdata_o=0.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears on grant and increments each granted cycle without mem_ack_i. Width is $clog2(TIMEOUT_CYCLES+1).
  - In the cycle where counter==TIMEOUT_CYCLES-1 and mem_ack_i=0: the granted port gets ack_o=1, err_o=1 and rdata_o=0. Next state is IDLE.
  - mem_req_o is therefore high for exactly TIMEOUT_CYCLES cycles.
  - If mem_ack_i and expiry occur in the same cycle, the ack wins and err_o=0.
  - A late mem_ack_i after abort arrives in IDLE and is ignored.
- Reset mid-transaction: the transaction is dropped and no ack is produced. Requesters must reissue.

Test Plan:
- Params MEM_ADDR_WIDTH=16, MEM_DATA_WIDTH=16, TIMEOUT_CYCLES=4 unless noted.
- imem_req_i=1, addr 0x0100; memory acks 2 cycles after mem_req_o rises with rdata 0xBEEF -> mem_req_o rises 1 cycle after request, mem_addr_o=0x0100, mem_we_o=0; imem_ack_o=1 and imem_rdata_o=0xBEEF in the mem_ack_i cycle; dmem_ack_o=0 throughout.
- After reset, raise both requests in the same cycle: D = write 0x1234 to 0x0200, I = read 0x0010 -> D granted first (mem_we_o=1, mem_wdata_o=0x1234), then I (mem_we_o=0, mem_addr_o=0x0010); each ack returns only to its owner.
- Both requests held continuously for 4 transactions, memory acking immediately -> grant order D,I,D,I; mem_req_o low exactly 1 cycle between transactions.
- dmem read to 0x0300 with memory never acking -> mem_req_o high exactly 4 cycles; dmem_ack_o=1, dmem_err_o=1, dmem_rdata_o=0 in the 4th cycle; a mem_ack_i 2 cycles later produces no ack.
- mem_ack_i arrives in the same cycle as expiry -> ack=1, err=0, rdata=mem_rdata_i.
- Assert arst_ni low while GNT_I is waiting -> all outputs 0 immediately; a stray mem_ack_i after release is ignored; a fresh request is then served normally.
